// File: rtl/lvds_tx.sv
// lvds_tx: TX framer that serializes 32-bit I/Q words into 16 DDR dibits, MSB dibit first.
// Build macro LVDS_TX_SYNC_CHECK_EN: check sync bits and drop bad words instead of forcing them.
//
// state | meaning
// IDLE  | drive IDLE_DIBIT, pull a word when enabled and the FIFO has data
// FETCH | capture FIFO word, drive dibit0 (or drop it when sync check fails)
// TX    | shift out dibits 1..15; last cycle may pull the next word back-to-back
// GAP   | hold IDLE_DIBIT so MIN_GAP idle dibits separate consecutive frames
module lvds_tx #(
  parameter logic [1:0]  IDLE_DIBIT = 2'b00,
  parameter int unsigned MIN_GAP    = 0
) (
  input  logic        i_ddr_clk,
  input  logic        i_rst,
  input  logic        i_tx_en,
  input  logic        i_fifo_empty,
  output logic        o_fifo_read_clk,
  output logic        o_fifo_pull,
  input  logic [31:0] i_fifo_data,
  output logic [1:0]  o_ddr_data,
  output logic        o_underrun,
  output logic        o_sync_err,
  output logic [7:0]  o_sync_err_cnt,
  output logic [1:0]  o_debug_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_TX    = 2'b11,
    ST_GAP   = 2'b10
  } state_t;

  // Pull-to-dibit0 latency is two cycles, so GAP only needs MIN_GAP-1 cycles of its own.
  localparam bit         B2B      = (MIN_GAP == 0);
  localparam bit         USE_GAP  = (MIN_GAP >= 2);
  localparam logic [3:0] GAP_LOAD = USE_GAP ? 4'(MIN_GAP - 2) : 4'd0;

  state_t      state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic [3:0]  pos_q, pos_d;
  logic [3:0]  gap_q, gap_d;
  logic [1:0]  ddr_q, ddr_d;
  logic        urun_pend_q, urun_pend_d;
  logic        urun_q, urun_d;
  logic [31:0] word;
  logic        word_ok;
  logic        last_tx;
  logic        pull;

`ifdef LVDS_TX_SYNC_CHECK_EN
  assign word    = i_fifo_data;
  assign word_ok = (i_fifo_data[31:30] == 2'b10) && (i_fifo_data[15:14] == 2'b01);
`else
  logic unused_sync_bits;
  assign unused_sync_bits = ^{i_fifo_data[31:30], i_fifo_data[15:14]};
  assign word    = {2'b10, i_fifo_data[29:16], 2'b01, i_fifo_data[13:0]};
  assign word_ok = 1'b1;
`endif

  assign last_tx = (state_q == ST_TX) && (pos_q == 4'd0);
  assign pull    = i_tx_en && !i_fifo_empty && !i_rst &&
                   ((state_q == ST_IDLE) || (B2B && last_tx));

  always_ff @(posedge i_ddr_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      pos_q       <= '0;
      gap_q       <= '0;
      ddr_q       <= IDLE_DIBIT;
      urun_pend_q <= 1'b0;
      urun_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      pos_q       <= pos_d;
      gap_q       <= gap_d;
      ddr_q       <= ddr_d;
      urun_pend_q <= urun_pend_d;
      urun_q      <= urun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pull) state_d = ST_FETCH;
      ST_FETCH: state_d = word_ok ? ST_TX : ST_IDLE;
      ST_TX: begin
        if (last_tx) begin
          if (pull)         state_d = ST_FETCH;
          else if (USE_GAP) state_d = ST_GAP;
          else              state_d = ST_IDLE;
        end
      end
      ST_GAP:   if (gap_q == 4'd0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ddr_d       = IDLE_DIBIT;
    sr_d        = sr_q;
    pos_d       = pos_q;
    gap_d       = gap_q;
    urun_pend_d = 1'b0;
    urun_d      = urun_pend_q;
    case (state_q)
      ST_FETCH: begin
        if (word_ok) begin
          ddr_d = word[31:30];
          sr_d  = {word[29:0], 2'b00};
          pos_d = 4'd14;
        end
      end
      ST_TX: begin
        ddr_d = sr_q[31:30];
        sr_d  = {sr_q[29:0], 2'b00};
        pos_d = pos_q - 4'd1;
        // Underrun is judged on the last shift cycle, surfaced one cycle after dibit15.
        if (last_tx) begin
          urun_pend_d = i_tx_en && i_fifo_empty;
          gap_d       = GAP_LOAD;
        end
      end
      ST_GAP:  gap_d = gap_q - 4'd1;
      default: ;
    endcase
  end

`ifdef LVDS_TX_SYNC_CHECK_EN
  logic       serr_q, serr_d;
  logic [7:0] serr_cnt_q, serr_cnt_d;

  always_comb begin
    serr_d     = 1'b0;
    serr_cnt_d = serr_cnt_q;
    if ((state_q == ST_FETCH) && !word_ok) begin
      serr_d = 1'b1;
      if (serr_cnt_q != 8'hFF) serr_cnt_d = serr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_ddr_clk) begin
    if (i_rst) begin
      serr_q     <= 1'b0;
      serr_cnt_q <= '0;
    end else begin
      serr_q     <= serr_d;
      serr_cnt_q <= serr_cnt_d;
    end
  end

  assign o_sync_err     = serr_q;
  assign o_sync_err_cnt = serr_cnt_q;
`else
  assign o_sync_err     = 1'b0;
  assign o_sync_err_cnt = 8'd0;
`endif

  assign o_fifo_read_clk = i_ddr_clk;
  assign o_fifo_pull     = pull;
  assign o_ddr_data      = ddr_q;
  assign o_underrun      = urun_q;
  assign o_debug_state   = state_q;

endmodule

// File: tb/tb_lvds_tx.sv
// Bench for lvds_tx: two instances (MIN_GAP 0 and 3) checked every cycle against a schedule-based model.
module tb_lvds_tx;
  localparam logic [1:0] IDLE = 2'b00;
  localparam int HN = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        empty [2];
  logic [31:0] fdata [2];
  logic        rclk [2], pull [2], urun [2], serr [2];
  logic [1:0]  ddr [2], st [2];
  logic [7:0]  scnt [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit armed  = 1'b0;
  bit pulled [2];
  logic [31:0] fq0 [$];
  logic [31:0] fq1 [$];

  // model state
  int         allowed_from [2];
  int         frame_end [2];
  int         fetch_t [2];
  int         mcnt [2];
  logic [1:0] xd [2][64];
  bit         xu [2][64];
  bit         xs [2][64];

  // history of DUT outputs for literal checks
  logic [1:0] h_ddr [2][HN];
  logic [1:0] h_st [2][HN];
  logic       h_pull [2][HN];
  logic       h_urun [2][HN];
  logic       h_serr [2][HN];

  lvds_tx #(.IDLE_DIBIT(IDLE), .MIN_GAP(0)) u_dut0 (
    .i_ddr_clk(clk), .i_rst(rst), .i_tx_en(en), .i_fifo_empty(empty[0]),
    .o_fifo_read_clk(rclk[0]), .o_fifo_pull(pull[0]), .i_fifo_data(fdata[0]),
    .o_ddr_data(ddr[0]), .o_underrun(urun[0]), .o_sync_err(serr[0]),
    .o_sync_err_cnt(scnt[0]), .o_debug_state(st[0]));

  lvds_tx #(.IDLE_DIBIT(IDLE), .MIN_GAP(3)) u_dut1 (
    .i_ddr_clk(clk), .i_rst(rst), .i_tx_en(en), .i_fifo_empty(empty[1]),
    .o_fifo_read_clk(rclk[1]), .o_fifo_pull(pull[1]), .i_fifo_data(fdata[1]),
    .o_ddr_data(ddr[1]), .o_underrun(urun[1]), .o_sync_err(serr[1]),
    .o_sync_err_cnt(scnt[1]), .o_debug_state(st[1]));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] frame_of(input logic [31:0] w);
    logic [31:0] r;
    r = w;
    r[31:30] = 2'b10;
    r[15:14] = 2'b01;
    return r;
  endfunction

  function automatic bit sync_ok(input logic [31:0] w);
    return (w[31:30] == 2'b10) && (w[15:14] == 2'b01);
  endfunction

  always @(negedge clk) begin : cmp
    int s;
    int g;
    bit ep;
    bit ok;
    logic [31:0] w;
    for (int d = 0; d < 2; d++) begin
      s  = cyc % 64;
      g  = (d == 0) ? 0 : 3;
      ep = 1'b0;
      if (!rst && armed) begin
        if (cyc == frame_end[d] && en && empty[d]) xu[d][(cyc + 2) % 64] = 1'b1;
        ep = en && !empty[d] && (cyc >= allowed_from[d]);
      end
      if (armed) begin
        chk("ddr_data", d, 32'(ddr[d]), 32'(xd[d][s]));
        chk("underrun", d, 32'(urun[d]), 32'(xu[d][s]));
        chk("sync_err", d, 32'(serr[d]), 32'(xs[d][s]));
        chk("sync_err_cnt", d, 32'(scnt[d]), 32'(mcnt[d]));
        chk("fifo_pull", d, 32'(pull[d]), 32'(ep));
        chk("read_clk", d, 32'(rclk[d]), 32'(clk));
      end
      xd[d][s] = IDLE;
      xu[d][s] = 1'b0;
      xs[d][s] = 1'b0;
      if (rst) begin
        for (int k = 0; k < 64; k++) begin
          xd[d][k] = IDLE;
          xu[d][k] = 1'b0;
          xs[d][k] = 1'b0;
        end
        allowed_from[d] = cyc + 1;
        frame_end[d]    = -1;
        fetch_t[d]      = -1;
        mcnt[d]         = 0;
      end else if (armed) begin
        if (ep) begin
          fetch_t[d]      = cyc + 1;
          allowed_from[d] = cyc + 16 + g;
          frame_end[d]    = cyc + 16;
        end
        if (cyc == fetch_t[d]) begin
          w  = fdata[d];
          ok = 1'b1;
`ifdef LVDS_TX_SYNC_CHECK_EN
          ok = sync_ok(w);
`endif
          if (!ok) begin
            xs[d][(cyc + 1) % 64] = 1'b1;
            if (mcnt[d] < 255) mcnt[d]++;
            allowed_from[d] = cyc + 1;
            frame_end[d]    = -1;
          end else begin
            w = frame_of(w);
            for (int k = 0; k < 16; k++) xd[d][(cyc + 1 + k) % 64] = w[31 - 2 * k -: 2];
          end
        end
      end
      if (cyc < HN) begin
        h_ddr[d][cyc]  = ddr[d];
        h_st[d][cyc]   = st[d];
        h_pull[d][cyc] = pull[d];
        h_urun[d][cyc] = urun[d];
        h_serr[d][cyc] = serr[d];
      end
      pulled[d] = (pull[d] === 1'b1);
    end
    if (rst) armed = 1'b1;
    cyc++;
  end

  task automatic upd_empty();
    empty[0] = (fq0.size() == 0);
    empty[1] = (fq1.size() == 0);
  endtask

  task automatic push(input logic [31:0] w);
    fq0.push_back(w);
    fq1.push_back(w);
    upd_empty();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pulled[0] && fq0.size() > 0) fdata[0] = fq0.pop_front();
    if (pulled[1] && fq1.size() > 0) fdata[1] = fq1.pop_front();
    upd_empty();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    fq0.delete();
    fq1.delete();
    upd_empty();
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic int count_pull(input int d, input int a, input int b);
    int n = 0;
    for (int t = a; t < b; t++) if (h_pull[d][t] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_urun(input int d, input int a, input int b);
    int n = 0;
    for (int t = a; t < b; t++) if (h_urun[d][t] === 1'b1) n++;
    return n;
  endfunction

  function automatic int nth_pull(input int d, input int a, input int b, input int n);
    int c = 0;
    for (int t = a; t < b; t++) begin
      if (h_pull[d][t] === 1'b1) begin
        if (c == n) return t;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic logic [31:0] collect(input int d, input int t);
    logic [31:0] r = '0;
    for (int k = 0; k < 16; k++) r = {r[29:0], h_ddr[d][t + k]};
    return r;
  endfunction

  initial begin : stim
    int t0;
    logic [31:0] w [3];
    empty[0] = 1'b1; empty[1] = 1'b1;
    fdata[0] = '0;   fdata[1] = '0;
    pulled[0] = 1'b0; pulled[1] = 1'b0;

    // single known frame followed by underrun
    do_reset();
    t0 = cyc;
    push(32'hA5A55A5A);
    en = 1'b1;
    repeat (30) step();
    for (int d = 0; d < 2; d++) begin
      chk("reset_state", d, 32'(h_st[d][t0]), 32'd0);
      chk("reset_ddr", d, 32'(h_ddr[d][t0]), 32'(IDLE));
      chk("t1_pull_cycle", d, nth_pull(d, t0, cyc, 0), t0);
      chk("t1_pull_count", d, count_pull(d, t0, cyc), 1);
      chk("t1_latency_idle", d, 32'(h_ddr[d][t0 + 1]), 32'(IDLE));
      chk("t1_frame", d, collect(d, t0 + 2), 32'hA5A55A5A);
      chk("t1_underrun_at", d, 32'(h_urun[d][t0 + 18]), 32'd1);
      chk("t1_underrun_count", d, count_urun(d, t0, cyc), 1);
      chk("t1_idle_after", d, 32'(h_ddr[d][t0 + 18]), 32'(IDLE));
    end

    // three queued words: back-to-back on dut0, 3-dibit gaps on dut1
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      w[i] = frame_of($urandom);
      push(w[i]);
    end
    en = 1'b1;
    repeat (70) step();
    for (int i = 0; i < 3; i++) begin
      chk("t2_b2b_pull", 0, nth_pull(0, t0, cyc, i), t0 + 16 * i);
      chk("t2_b2b_frame", 0, collect(0, t0 + 2 + 16 * i), w[i]);
      chk("t2_gap_pull", 1, nth_pull(1, t0, cyc, i), t0 + 19 * i);
      chk("t2_gap_frame", 1, collect(1, t0 + 2 + 19 * i), w[i]);
    end
    chk("t2_underrun_count", 0, count_urun(0, t0, cyc), 1);
    chk("t2_underrun_at", 0, 32'(h_urun[0][t0 + 50]), 32'd1);
    chk("t2_underrun_count", 1, count_urun(1, t0, cyc), 1);
    chk("t2_underrun_at", 1, 32'(h_urun[1][t0 + 56]), 32'd1);
    chk("t2_gap_idles", 1, 32'({h_ddr[1][t0 + 18], h_ddr[1][t0 + 19], h_ddr[1][t0 + 20]}), 32'd0);

    // zero word then a word already carrying correct sync bits
    do_reset();
    t0 = cyc;
    push(32'h00000000);
    push(32'h80004000);
    en = 1'b1;
    repeat (60) step();
`ifdef LVDS_TX_SYNC_CHECK_EN
    chk("t3_drop_pull2", 0, nth_pull(0, t0, cyc, 1), t0 + 2);
    chk("t3_drop_idle", 0, 32'(h_ddr[0][t0 + 2]), 32'(IDLE));
    chk("t3_sync_err_at", 0, 32'(h_serr[0][t0 + 2]), 32'd1);
    chk("t3_sync_err_cnt", 0, 32'(scnt[0]), 32'd1);
    chk("t3_frame", 0, collect(0, t0 + 4), 32'h80004000);
`else
    chk("t3_pull2", 0, nth_pull(0, t0, cyc, 1), t0 + 16);
    chk("t3_forced_frame", 0, collect(0, t0 + 2), 32'h80004000);
    chk("t3_frame2", 0, collect(0, t0 + 18), 32'h80004000);
    chk("t3_sync_err_cnt", 0, 32'(scnt[0]), 32'd0);
`endif
    chk("t3_pull_count", 0, count_pull(0, t0, cyc), 2);

    // reset while dibit7 is on the wire
    do_reset();
    t0 = cyc;
    push(frame_of($urandom));
    en = 1'b1;
    repeat (9) step();
    rst = 1'b1;
    en  = 1'b0;
    step();
    rst = 1'b0;
    repeat (4) step();
    for (int d = 0; d < 2; d++) begin
      chk("t4_ddr_after_rst", d, 32'(h_ddr[d][t0 + 10]), 32'(IDLE));
      chk("t4_pull_after_rst", d, 32'(h_pull[d][t0 + 10]), 32'd0);
      chk("t4_state_after_rst", d, 32'(h_st[d][t0 + 10]), 32'd0);
    end

    // enable dropped mid-frame
    do_reset();
    t0 = cyc;
    w[0] = frame_of($urandom);
    push(w[0]);
    push(frame_of($urandom));
    en = 1'b1;
    repeat (6) step();
    en = 1'b0;
    repeat (30) step();
    for (int d = 0; d < 2; d++) begin
      chk("t5_pull_count", d, count_pull(d, t0, cyc), 1);
      chk("t5_no_underrun", d, count_urun(d, t0, cyc), 0);
      chk("t5_frame", d, collect(d, t0 + 2), w[0]);
    end

    // randomized traffic, enable toggling and occasional resets
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (($urandom % 4 == 0) && fq0.size() < 6) begin
`ifdef LVDS_TX_SYNC_CHECK_EN
        push(($urandom % 4 == 0) ? $urandom : frame_of($urandom));
`else
        push($urandom);
`endif
      end
      if ($urandom % 20 == 0) en = ~en;
      rst = ($urandom % 600 == 0);
    end
    rst = 1'b0;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lvds_tx.md
Name: lvds_tx

Overview:
- Transmit-side framer for the modem LVDS data path.
- Pulls 32-bit I/Q sample words from the TX FIFO and serializes each into 16 dibits on a 2-bit DDR data bus, MSB dibit first.
- Frame format: dibit0 = I sync 2'b10 (word[31:30]), dibit8 = Q sync 2'b01 (word[15:14]); the remaining 28 bits are payload.
- Sits between the TX sample FIFO and the LVDS output buffers; the mirror of the capture path on the modem side.

Parameters:
- IDLE_DIBIT, 2'b00, dibit driven when no frame is in flight; must not equal 2'b10.
- MIN_GAP, 0, number of IDLE_DIBIT cycles forced between consecutive frames (0..15).

Ports:
- i_ddr_clk  input  1  DDR bit clock; the single clock of the block.
- i_rst  input  1  synchronous active-high reset, sampled on rising edge of i_ddr_clk.
- i_tx_en  input  1  transmit enable; level, sampled each cycle.
- i_fifo_empty  input  1  TX FIFO empty flag.
- o_fifo_read_clk  output  1  equals i_ddr_clk.
- o_fifo_pull  output  1  one-cycle read strobe to the FIFO.
- i_fifo_data  input  32  FIFO read data; valid the cycle after o_fifo_pull, held until the next pull.
- o_ddr_data  output  2  registered serial dibit output.
- o_underrun  output  1  one-cycle pulse on stream break.
- o_sync_err  output  1  one-cycle pulse on dropped word (feature only).
- o_sync_err_cnt  output  8  saturating count of dropped words (feature only).
- o_debug_state  output  2  current FSM state.

Behaviour:
- Reset values: o_ddr_data=IDLE_DIBIT, o_fifo_pull=0, o_underrun=0, o_sync_err=0, o_sync_err_cnt=0, state=IDLE, gap counter=0.
- A reset mid-frame abandons the frame. IDLE_DIBIT is on o_ddr_data the cycle after reset is sampled.
- States and encodings: IDLE 2'b00, FETCH 2'b01, TX 2'b11, GAP 2'b10.
- IDLE: if i_tx_en=1 and i_fifo_empty=0, assert o_fifo_pull for one cycle, then go to FETCH. Otherwise drive IDLE_DIBIT.
- FETCH: capture i_fifo_data, apply the sync rule, drive dibit0, then go to TX.
- Latency: pull at cycle N → dibit0 on o_ddr_data at N+2.
- TX: shift out dibits 1..15 on consecutive cycles; a 4-bit down-counter tracks position.
- Back-to-back:
  - Applies when MIN_GAP=0, i_tx_en=1 and the FIFO is non-empty.
  - The next pull is issued early enough that dibit0 of frame n+1 directly follows dibit15 of frame n.
  - Pulls are then exactly 16 cycles apart, with no idle dibit between frames.
- End of frame with MIN_GAP>0: go to GAP and drive IDLE_DIBIT for exactly MIN_GAP cycles, then re-evaluate the IDLE conditions.
- Underrun: a frame ends with i_tx_en=1 and i_fifo_empty=1 → o_underrun=1 on the cycle after dibit15, then IDLE.
- i_tx_en deasserted mid-frame: the current frame completes, no further pull, no underrun pulse.
- o_fifo_pull is never asserted while i_fifo_empty=1, and never more than once per frame.
- Sync rule, feature off: word[31:30] is forced to 2'b10 and word[15:14] to 2'b01; the other bits pass unchanged.

Optional Feature:
- Macro: LVDS_TX_SYNC_CHECK_EN.
- When defined, sync bits are checked rather than forced. In FETCH, a word with word[31:30]!=2'b10 or word[15:14]!=2'b01 is:
  - discarded, with IDLE_DIBIT driven;
  - reported with o_sync_err=1 for one cycle;
  - counted by incrementing o_sync_err_cnt, saturating at 255.
- After a drop the FSM returns to IDLE, so the next pull occurs one cycle later at the earliest.
- When not defined: the forcing rule applies, o_sync_err and o_sync_err_cnt are tied to 0, and no check logic is built.

Test Plan:
- Reset, i_tx_en=1, FIFO holds 0xA5A55A5A → one pull; two cycles later o_ddr_data = 10,10,01,01,10,10,01,01,01,01,10,10,01,01,10,10; then o_underrun pulse, then 00.
- MIN_GAP=0, three words queued → pulls 16 cycles apart; 48 contiguous dibits; single o_underrun after the last.
- MIN_GAP=3, two words → exactly three 2'b00 dibits between the frames.
- Feature off, word 0x00000000 → dibits 10, 00×7, 01, 00×7.
- Feature on, word 0x00000000 followed by 0x80004000 → first word dropped, o_sync_err pulse, o_sync_err_cnt=1; second frame transmitted intact.
- i_rst asserted at dibit 7 → o_ddr_data=00 next cycle, o_fifo_pull=0, state 2'b00; i_tx_en dropped mid-frame → frame completes, no pull, no underrun.
